// File: rtl/button_pkg.sv
// Shared field layout and helpers for the button event register.
package button_pkg;

  localparam int BTN_EMPTY = 0;

  function automatic int btn_valid_bit(input int data_w);
    return data_w - 1;
  endfunction

  function automatic int btn_ovf_bit(input int data_w);
    return data_w - 2;
  endfunction

  function automatic int btn_idx_w(input int n_btn);
    return (n_btn > 1) ? $clog2(n_btn) : 1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button channel: 2-flop synchroniser, stability counter, debounced level
// and a one-cycle press pulse on each debounced 0->1 transition.
module button_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      // Level flips only after DEB_CYCLES consecutive disagreeing samples.
      if (sync_p1 != level) begin
        if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
          level <= ~level;
          cnt   <= '0;
          press <= ~level;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/button_event_reg.sv
// N-channel button front end: debounced presses are queued through a
// lowest-index-first arbiter into a small FIFO that the CPU pops per read edge.
module button_event_reg
  import button_pkg::*;
#(
  parameter int N_BTN      = 2,
  parameter int DEB_CYCLES = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_BTN-1:0]  btn,
  input  logic              button_read,
  output logic [DATA_W-1:0] button_op,
  output logic              evt_pending,
  output logic              fifo_full
);

  localparam int IDX_W     = btn_idx_w(N_BTN);
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int VALID_BIT = btn_valid_bit(DATA_W);
  localparam int OVF_BIT   = btn_ovf_bit(DATA_W);

  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] grant_oh;
  logic [IDX_W-1:0] grant_idx;
  logic             push;
  logic             pop;
  logic             rd_prev;
  logic             rd_edge;
  logic             not_empty;
  logic             full;
  logic             ovf;
  logic             ovf_set;
  logic [IDX_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [DATA_W-1:0] rd_word;

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    button_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .btn  (btn[g]),
      .press(press[g])
    );
  end

  assign rd_edge   = button_read & ~rd_prev;
  assign not_empty = (count != '0);
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign pop       = rd_edge & not_empty;

  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  always_comb begin
    grant_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pending[i]) grant_idx = IDX_W'(i);
    end
    push = (pending != '0) && (!full || pop);
    for (int i = 0; i < N_BTN; i++) begin
      grant_oh[i] = push && (grant_idx == IDX_W'(i));
    end
  end

  assign ovf_set = |(press & pending & ~grant_oh);

  always_comb begin
    rd_word               = '0;
    rd_word[VALID_BIT]    = 1'b1;
    rd_word[OVF_BIT]      = ovf;
    rd_word[IDX_W-1:0]    = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= grant_idx;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_prev     <= 1'b0;
      pending     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ovf         <= 1'b0;
      button_op   <= DATA_W'(BTN_EMPTY);
      evt_pending <= 1'b0;
      fifo_full   <= 1'b0;
    end else begin
      rd_prev <= button_read;
      pending <= (pending & ~grant_oh) | press;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (rd_edge) button_op <= pop ? rd_word : DATA_W'(BTN_EMPTY);
      ovf         <= (ovf & ~pop) | ovf_set;
      evt_pending <= not_empty;
      fifo_full   <= full;
    end
  end

endmodule

// File: tb/tb_button_event_reg.sv
// Directed bench for button_event_reg with N_BTN=2, DEB_CYCLES=4, FIFO_DEPTH=4.
module tb_button_event_reg;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] btn = 2'b00;
  logic       button_read = 1'b0;
  logic [7:0] button_op;
  logic       evt_pending;
  logic       fifo_full;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  button_event_reg #(
    .N_BTN(2), .DEB_CYCLES(4), .FIFO_DEPTH(4), .DATA_W(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .button_read(button_read),
    .button_op  (button_op),
    .evt_pending(evt_pending),
    .fifo_full  (fifo_full)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Hold the mask long enough to debounce, then release and let it settle.
  task automatic press_btn(input logic [1:0] m);
    btn = m;
    tick(8);
    btn = 2'b00;
    tick(8);
  endtask

  task automatic do_read(input string tag, input logic [7:0] exp);
    button_read = 1'b1;
    tick(1);
    chk(tag, button_op, exp);
    button_read = 1'b0;
    tick(1);
    chk({tag, "_hold"}, button_op, exp);
  endtask

  initial begin
    reset = 1'b0;
    tick(3);
    chk("rst_op", button_op, 8'h00);
    chk("rst_evt", evt_pending, 1'b0);
    chk("rst_full", fifo_full, 1'b0);
    reset = 1'b1;
    tick(2);

    // Reset discards queued events and a bouncing input.
    press_btn(2'b01);
    press_btn(2'b10);
    press_btn(2'b01);
    do_read("t1_pre", 8'h80);
    chk("t1_pre_evt", evt_pending, 1'b1);
    for (int i = 0; i < 6; i++) begin
      btn[0] = ~btn[0];
      tick(1);
    end
    reset = 1'b0;
    tick(1);
    chk("t1_rst_op", button_op, 8'h00);
    chk("t1_rst_evt", evt_pending, 1'b0);
    chk("t1_rst_full", fifo_full, 1'b0);
    reset = 1'b1;
    btn = 2'b00;
    tick(10);
    chk("t1_evt_after", evt_pending, 1'b0);
    do_read("t1_read_after", 8'h00);

    // Press-to-pending latency.
    btn = 2'b01;
    tick(8);
    chk("t2_evt_8", evt_pending, 1'b0);
    tick(1);
    chk("t2_evt_9", evt_pending, 1'b1);
    tick(1);
    btn = 2'b00;
    tick(10);
    do_read("t2_read1", 8'h80);
    chk("t2_evt_drained", evt_pending, 1'b0);
    do_read("t2_read2", 8'h00);

    // Short glitches never debounce.
    for (int i = 0; i < 5; i++) begin
      btn = 2'b01;
      tick(3);
      btn = 2'b00;
      tick(3);
    end
    tick(10);
    chk("t3_evt", evt_pending, 1'b0);
    do_read("t3_read", 8'h00);

    // Simultaneous presses enter in ascending index order.
    press_btn(2'b11);
    chk("t4_evt", evt_pending, 1'b1);
    do_read("t4_read0", 8'h80);
    do_read("t4_read1", 8'h81);
    do_read("t4_read2", 8'h00);

    // Full FIFO, held pending event and coalescing overflow.
    press_btn(2'b10);
    press_btn(2'b01);
    press_btn(2'b10);
    press_btn(2'b01);
    chk("t5_full4", fifo_full, 1'b1);
    press_btn(2'b10);
    press_btn(2'b10);
    press_btn(2'b10);
    chk("t5_full_hold", fifo_full, 1'b1);
    chk("t5_evt", evt_pending, 1'b1);
    do_read("t5_read0", 8'hC1);
    chk("t5_full_after_pop", fifo_full, 1'b1);
    do_read("t5_read1", 8'h80);
    do_read("t5_read2", 8'h81);
    do_read("t5_read3", 8'h80);
    do_read("t5_read4", 8'h81);
    do_read("t5_read5", 8'h00);
    chk("t5_full_end", fifo_full, 1'b0);
    chk("t5_evt_end", evt_pending, 1'b0);

    // A held strobe pops exactly once.
    press_btn(2'b01);
    press_btn(2'b10);
    press_btn(2'b01);
    button_read = 1'b1;
    tick(1);
    chk("t6_first", button_op, 8'h80);
    for (int i = 0; i < 19; i++) begin
      tick(1);
      chk("t6_stable", button_op, 8'h80);
    end
    chk("t6_evt", evt_pending, 1'b1);
    button_read = 1'b0;
    tick(1);
    do_read("t6_read1", 8'h81);
    do_read("t6_read2", 8'h80);
    do_read("t6_read3", 8'h00);
    chk("t6_evt_end", evt_pending, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
